// File: rtl/max7219_monitor.sv
// MAX7219 bus monitor: samples the serial pins, rebuilds 16-bit frames and
// mirrors the chip's digit/control registers with a recovered hex value per digit.
module max7219_monitor #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        din,
   input  logic        load,
   output logic [31:0] num,
   output logic [7:0]  num_valid,
   output logic [7:0]  dp,
   output logic [63:0] seg_raw,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        shutdown,
   output logic        display_test,
   output logic        frame_strobe,
   output logic        frame_err
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, din_sync_q, load_sync_q;
   logic sclk_prev_q, load_prev_q;
   logic sclk_s, din_s, load_s;
   logic sclk_rise, load_rise, load_fall;

   logic [15:0] shift_q, shift_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] seg_q, seg_d;
   logic [7:0]  dec_q, dec_d;
   logic [3:0]  inten_q, inten_d;
   logic [2:0]  scan_q, scan_d;
   logic        shut_q, shut_d;
   logic        test_q, test_d;
   logic        strobe_q, strobe_d;
   logic        err_q, err_d;
   logic        unused_hi;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign din_s     = din_sync_q[SYNC_STAGES-1];
   assign load_s    = load_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign load_rise = load_s & ~load_prev_q;
   assign load_fall = ~load_s & load_prev_q;
   assign unused_hi = ^shift_d[15:12];

   // Pin synchronizers and previous-value registers for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         din_sync_q  <= '0;
         load_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         load_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
         load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load};
         sclk_prev_q <= sclk_s;
         load_prev_q <= load_s;
      end
   end

   // Frame state, shifter and register file
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         seg_q    <= '0;
         dec_q    <= '0;
         inten_q  <= '0;
         scan_q   <= '0;
         shut_q   <= 1'b1;
         test_q   <= 1'b0;
         strobe_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         seg_q    <= seg_d;
         dec_q    <= dec_d;
         inten_q  <= inten_d;
         scan_q   <= scan_d;
         shut_q   <= shut_d;
         test_q   <= test_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
      end
   end

   // Next state: shift on sclk, then judge frame length on load rise
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      seg_d    = seg_q;
      dec_d    = dec_q;
      inten_d  = inten_q;
      scan_d   = scan_q;
      shut_d   = shut_q;
      test_d   = test_q;
      strobe_d = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (sclk_rise) begin
               shift_d = {shift_q[14:0], din_s};
               if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
            end
            if (load_rise) begin
               state_d = IDLE;
               if (cnt_d == 5'd16) begin
                  strobe_d = 1'b1;
                  case (shift_d[11:8])
                     4'h1: seg_d[7:0]   = shift_d[7:0];
                     4'h2: seg_d[15:8]  = shift_d[7:0];
                     4'h3: seg_d[23:16] = shift_d[7:0];
                     4'h4: seg_d[31:24] = shift_d[7:0];
                     4'h5: seg_d[39:32] = shift_d[7:0];
                     4'h6: seg_d[47:40] = shift_d[7:0];
                     4'h7: seg_d[55:48] = shift_d[7:0];
                     4'h8: seg_d[63:56] = shift_d[7:0];
                     4'h9: dec_d   = shift_d[7:0];
                     4'hA: inten_d = shift_d[3:0];
                     4'hB: scan_d  = shift_d[2:0];
                     4'hC: shut_d  = ~shift_d[0];
                     4'hF: test_d  = shift_d[0];
                     default: ;
                  endcase
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Segment pattern (GFEDCBA) or Code-B nibble to {valid, value}
   function automatic logic [4:0] digit_decode(input logic [7:0] raw,
                                              input logic code_b);
      logic [6:0] seg;
      logic [4:0] r;
      seg = {raw[0], raw[1], raw[2], raw[3], raw[4], raw[5], raw[6]};
      r = 5'h00;
      if (code_b) begin
         if (raw[3:0] < 4'd10) r = {1'b1, raw[3:0]};
      end else begin
         case (seg)
            7'h3F: r = 5'h10;
            7'h06: r = 5'h11;
            7'h5B: r = 5'h12;
            7'h4F: r = 5'h13;
            7'h66: r = 5'h14;
            7'h6D: r = 5'h15;
            7'h7D: r = 5'h16;
            7'h27: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h6F: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h7C: r = 5'h1B;
            7'h39: r = 5'h1C;
            7'h5E: r = 5'h1D;
            7'h79: r = 5'h1E;
            7'h71: r = 5'h1F;
            default: r = 5'h00;
         endcase
      end
      return r;
   endfunction

   for (genvar k = 0; k < 8; k++) begin : g_dig
      logic [4:0] res;
      assign res             = digit_decode(seg_q[8*k +: 8], dec_q[k]);
      assign num[4*k +: 4]   = res[3:0];
      assign num_valid[k]    = res[4];
      assign dp[k]           = seg_q[8*k+7];
   end

   assign seg_raw      = seg_q;
   assign decode_mode  = dec_q;
   assign intensity    = inten_q;
   assign scan_limit   = scan_q;
   assign shutdown     = shut_q;
   assign display_test = test_q;
   assign frame_strobe = strobe_q;
   assign frame_err    = err_q;

endmodule

// File: tb/tb_max7219_monitor.sv
// Directed bench for max7219_monitor: table of serial frames with the
// expected register mirror after each, plus reset and edge-coincidence cases.
module tb_max7219_monitor;

   logic        clk = 1'b0;
   logic        rst, sclk, din, load;
   logic [31:0] num;
   logic [7:0]  num_valid, dp, decode_mode;
   logic [63:0] seg_raw;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic        shutdown, display_test, frame_strobe, frame_err;

   max7219_monitor #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .din(din), .load(load),
      .num(num), .num_valid(num_valid), .dp(dp), .seg_raw(seg_raw),
      .decode_mode(decode_mode), .intensity(intensity),
      .scan_limit(scan_limit), .shutdown(shutdown),
      .display_test(display_test), .frame_strobe(frame_strobe),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] word;
      int          nbits;
      int          strobes;
      int          errs;
      logic [31:0] num;
      logic [7:0]  valid;
      logic [7:0]  dp;
      logic [7:0]  dec;
      logic [3:0]  inten;
      logic [2:0]  scan;
      logic        shut;
      logic        test;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_s, pulse_e, lat;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Observe a fixed window after load rises; record pulses and latency
   task automatic watch();
      pulse_s = 0;
      pulse_e = 0;
      lat     = -1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if ((frame_strobe || frame_err) && lat < 0) lat = c;
         if (frame_strobe) pulse_s++;
         if (frame_err) pulse_e++;
      end
   endtask

   task automatic clock_bit(input logic b);
      din = b;
      tick(2);
      sclk = 1'b1;
      tick(2);
      sclk = 1'b0;
      tick(1);
   endtask

   // Send nb bits of w MSB first; simult raises load with the last sclk edge
   task automatic send_frame(input logic [31:0] w, input int nb,
                             input bit simult);
      load = 1'b0;
      tick(3);
      for (int i = nb - 1; i >= 1; i--) clock_bit(w[i]);
      din = w[0];
      tick(2);
      sclk = 1'b1;
      if (simult) begin
         load = 1'b1;
      end else begin
         tick(2);
         sclk = 1'b0;
         tick(2);
         load = 1'b1;
      end
      watch();
      sclk = 1'b0;
      tick(2);
   endtask

   initial begin
      vecs[0]  = '{32'h0130, 16, 1, 0, 32'h00000001, 8'h01, 8'h00, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[1]  = '{32'h08FF, 16, 1, 0, 32'h80000001, 8'h81, 8'h80, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[2]  = '{32'h0880, 16, 1, 0, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[3]  = '{32'h09FF, 16, 1, 0, 32'h00000000, 8'hFF, 8'h80, 8'hFF, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[4]  = '{32'h0305, 16, 1, 0, 32'h00000500, 8'hFF, 8'h80, 8'hFF, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[5]  = '{32'h030A, 16, 1, 0, 32'h00000000, 8'hFB, 8'h80, 8'hFF, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[6]  = '{32'h0900, 16, 1, 0, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[7]  = '{32'h0C01, 15, 0, 1, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[8]  = '{32'h10C01, 17, 0, 1, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h0, 3'd0, 1'b1, 1'b0};
      vecs[9]  = '{32'h0C01, 16, 1, 0, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0};
      vecs[10] = '{32'h0A37, 16, 1, 0, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h7, 3'd0, 1'b0, 1'b0};
      vecs[11] = '{32'h0B05, 16, 1, 0, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h7, 3'd5, 1'b0, 1'b0};
      vecs[12] = '{32'h0F01, 16, 1, 0, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h7, 3'd5, 1'b0, 1'b1};
      vecs[13] = '{32'h0D55, 16, 1, 0, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h7, 3'd5, 1'b0, 1'b1};
      vecs[14] = '{32'h0055, 16, 1, 0, 32'h00000001, 8'h01, 8'h80, 8'h00, 4'h7, 3'd5, 1'b0, 1'b1};
      vecs[15] = '{32'hF46D, 16, 1, 0, 32'h00002001, 8'h09, 8'h80, 8'h00, 4'h7, 3'd5, 1'b0, 1'b1};
      vecs[16] = '{32'h0C00, 16, 1, 0, 32'h00002001, 8'h09, 8'h80, 8'h00, 4'h7, 3'd5, 1'b1, 1'b1};

      rst  = 1'b1;
      sclk = 1'b0;
      din  = 1'b0;
      load = 1'b1;
      tick(3);
      chk("rst_num", num, 0);
      chk("rst_valid", num_valid, 0);
      chk("rst_dp", dp, 0);
      chk("rst_seg", seg_raw, 0);
      chk("rst_dec", decode_mode, 0);
      chk("rst_int", intensity, 0);
      chk("rst_scan", scan_limit, 0);
      chk("rst_shut", shutdown, 1);
      chk("rst_test", display_test, 0);
      chk("rst_strobe", frame_strobe, 0);
      chk("rst_err", frame_err, 0);
      rst = 1'b0;
      tick(4);
      chk("post_rst_shut", shutdown, 1);

      for (int v = 0; v < NV; v++) begin
         send_frame(vecs[v].word, vecs[v].nbits, 1'b0);
         $display("vector %0d frame 0x%0h bits %0d", v, vecs[v].word,
                  vecs[v].nbits);
         chk("strobes", pulse_s, vecs[v].strobes);
         chk("errs", pulse_e, vecs[v].errs);
         chk("latency", lat, 3);
         chk("num", num, vecs[v].num);
         chk("valid", num_valid, vecs[v].valid);
         chk("dp", dp, vecs[v].dp);
         chk("dec", decode_mode, vecs[v].dec);
         chk("int", intensity, vecs[v].inten);
         chk("scan", scan_limit, vecs[v].scan);
         chk("shut", shutdown, vecs[v].shut);
         chk("test", display_test, vecs[v].test);
      end
      chk("seg_d0", seg_raw[7:0], 8'h30);
      chk("seg_d2", seg_raw[23:16], 8'h0A);
      chk("seg_d3", seg_raw[31:24], 8'h6D);

      // Last sclk edge and load rise land in the same cycle
      send_frame(32'h0B03, 16, 1'b1);
      chk("sim_strobes", pulse_s, 1);
      chk("sim_errs", pulse_e, 0);
      chk("sim_latency", lat, 3);
      chk("sim_scan", scan_limit, 3'd3);

      // Reset in the middle of a frame, then the stale load rise
      load = 1'b0;
      tick(3);
      for (int i = 15; i >= 8; i--) clock_bit(logic'((32'h0A0F >> i) & 1));
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(3);
      load = 1'b1;
      watch();
      chk("mid_rst_strobes", pulse_s, 0);
      chk("mid_rst_errs", pulse_e, 0);
      chk("mid_rst_int", intensity, 0);
      chk("mid_rst_scan", scan_limit, 0);
      chk("mid_rst_shut", shutdown, 1);
      chk("mid_rst_valid", num_valid, 0);
      chk("mid_rst_seg", seg_raw, 0);
      tick(2);
      send_frame(32'h0A0F, 16, 1'b0);
      chk("after_rst_strobes", pulse_s, 1);
      chk("after_rst_errs", pulse_e, 0);
      chk("after_rst_int", intensity, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
